// File: rtl/brc_seq.sv
// rtl/brc_seq.sv - multi-cycle chunked branch comparator with early exit and valid/ready handshake
module brc_seq #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [2:0]       i_funct3,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal,
    output logic             o_br_taken,
    output logic             o_illegal
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       f3_q, f3_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;
    logic             out_less_q, out_less_d;
    logic             out_equal_q, out_equal_d;
    logic             out_taken_q, out_taken_d;
    logic             out_illegal_q, out_illegal_d;

    logic [CHUNK-1:0] ca, cb;
    logic             diff_c, less_c, equal_c, decided_c, finish_c, taken_c;

    // Current chunk compare; in signed mode the top chunk's sign bits are flipped
    // so an unsigned compare orders two's-complement values correctly.
    always_comb begin
        ca = a_q[idx_q*CHUNK +: CHUNK];
        cb = b_q[idx_q*CHUNK +: CHUNK];
        if (!f3_q[1] && (idx_q == TOP_IDX)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        diff_c    = (ca != cb);
        decided_c = decided_q | diff_c;
        if (decided_q) begin
            less_c  = less_q;
            equal_c = equal_q;
        end else if (diff_c) begin
            less_c  = (ca < cb);
            equal_c = 1'b0;
        end else begin
            less_c  = 1'b0;
            equal_c = (idx_q == '0);
        end
        if (EARLY_EXIT != 0) begin
            finish_c = decided_c | (idx_q == '0);
        end else begin
            finish_c = (idx_q == '0);
        end
        case (f3_q)
            3'b000:         taken_c = equal_c;
            3'b001:         taken_c = ~equal_c;
            3'b100, 3'b110: taken_c = less_c;
            3'b101, 3'b111: taken_c = ~less_c;
            default:        taken_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        f3_d          = f3_q;
        idx_d         = idx_q;
        decided_d     = decided_q;
        less_d        = less_q;
        equal_d       = equal_q;
        out_less_d    = out_less_q;
        out_equal_d   = out_equal_q;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d       = i_rs1_data;
                    b_d       = i_rs2_data;
                    f3_d      = i_funct3;
                    idx_d     = TOP_IDX;
                    decided_d = 1'b0;
                    less_d    = 1'b0;
                    equal_d   = 1'b0;
                    state_d   = CMP;
                end
            end
            CMP: begin
                decided_d = decided_c;
                less_d    = less_c;
                equal_d   = equal_c;
                if (finish_c) begin
                    state_d       = DONE;
                    out_less_d    = less_c;
                    out_equal_d   = equal_c;
                    out_taken_d   = taken_c;
                    out_illegal_d = (f3_q[2:1] == 2'b01);
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                // Results are zeroed on leaving DONE so they read 0 whenever o_valid is low.
                if (i_ready) begin
                    state_d       = IDLE;
                    out_less_d    = 1'b0;
                    out_equal_d   = 1'b0;
                    out_taken_d   = 1'b0;
                    out_illegal_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            f3_q          <= '0;
            idx_q         <= '0;
            decided_q     <= 1'b0;
            less_q        <= 1'b0;
            equal_q       <= 1'b0;
            out_less_q    <= 1'b0;
            out_equal_q   <= 1'b0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            f3_q          <= f3_d;
            idx_q         <= idx_d;
            decided_q     <= decided_d;
            less_q        <= less_d;
            equal_q       <= equal_d;
            out_less_q    <= out_less_d;
            out_equal_q   <= out_equal_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign o_ready    = (state_q == IDLE) && !i_rst;
    assign o_valid    = (state_q == DONE);
    assign o_br_less  = out_less_q;
    assign o_br_equal = out_equal_q;
    assign o_br_taken = out_taken_q;
    assign o_illegal  = out_illegal_q;

endmodule

// File: tb/tb_brc_seq.sv
// tb/tb_brc_seq.sv - self-checking bench for brc_seq (early-exit, constant-latency and single-chunk builds)
module tb_brc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready = 1'b1;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  f3 = '0;
    logic [2:0]  rdy, vo, less, eq, tk, il;
    logic [3:0]  res_o [3];

    int          tests = 0;
    int          failed = 0;
    int          obs_k [3];
    logic [3:0]  obs_res [3];

    always #5 clk = ~clk;

    brc_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy[0]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_funct3(f3), .o_valid(vo[0]),
        .i_ready(in_ready), .o_br_less(less[0]), .o_br_equal(eq[0]),
        .o_br_taken(tk[0]), .o_illegal(il[0]));

    brc_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy[1]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_funct3(f3), .o_valid(vo[1]),
        .i_ready(in_ready), .o_br_less(less[1]), .o_br_equal(eq[1]),
        .o_br_taken(tk[1]), .o_illegal(il[1]));

    brc_seq #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy[2]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_funct3(f3), .o_valid(vo[2]),
        .i_ready(in_ready), .o_br_less(less[2]), .o_br_equal(eq[2]),
        .o_br_taken(tk[2]), .o_illegal(il[2]));

    assign res_o[0] = {less[0], eq[0], tk[0], il[0]};
    assign res_o[1] = {less[1], eq[1], tk[1], il[1]};
    assign res_o[2] = {less[2], eq[2], tk[2], il[2]};

    // Reference: {less, equal, taken, illegal} straight from the RISC-V branch rules.
    function automatic logic [3:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f);
        logic lt, e, t, ill;
        e   = (a == b);
        lt  = f[1] ? (a < b) : ($signed(a) < $signed(b));
        ill = (f[2:1] == 2'b01);
        case (f)
            3'b000:         t = e;
            3'b001:         t = !e;
            3'b100, 3'b110: t = lt;
            3'b101, 3'b111: t = !lt;
            default:        t = 1'b0;
        endcase
        return {lt, e, t, ill};
    endfunction

    // Chunks examined with byte chunks and early exit: up to and including the first differing byte from the top.
    function automatic int model_k(input logic [31:0] a, input logic [31:0] b);
        for (int i = 3; i >= 0; i--) begin
            if (a[8*i +: 8] != b[8*i +: 8]) return 4 - i;
        end
        return 4;
    endfunction

    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [2:0] seen;
        @(negedge clk);
        rs1 = a; rs2 = b; f3 = f; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seen = '0;
        for (int d = 0; d < 3; d++) begin
            obs_k[d] = 0;
            obs_res[d] = 'x;
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && vo[d]) begin
                    seen[d] = 1'b1;
                    obs_k[d] = c;
                    obs_res[d] = res_o[d];
                end
            end
            if (seen == 3'b111) break;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (rdy !== 3'b000 || vo !== 3'b000) begin
            failed++;
            $display("FAIL reset_rdy_valid: rdy=%b valid=%b required rdy=000 valid=000", rdy, vo);
        end
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (res_o[d] !== 4'b0000) begin
                failed++;
                $display("FAIL reset_results dut%0d: got %b required 0000", d, res_o[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (rdy !== 3'b111 || vo !== 3'b000) begin
            failed++;
            $display("FAIL ready_after_reset: rdy=%b valid=%b required rdy=111 valid=000", rdy, vo);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [8] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0010,
                                32'h0100_0000, 32'h0000_0003, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb [8] = '{32'h1234_5678, 32'h0000_0001, 32'h0000_0001, 32'h0000_0020,
                                32'h0000_0000, 32'h0000_0005, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic [2:0]  tf [8] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b111, 3'b010, 3'b101, 3'b001};
        int          tk0 [8] = '{4, 1, 1, 4, 1, 4, 1, 1};
        logic [3:0]  tr [8] = '{4'b0110, 4'b1010, 4'b0000, 4'b1000,
                                4'b0010, 4'b1001, 4'b1000, 4'b1010};
        for (int i = 0; i < 8; i++) begin
            run_req(ta[i], tb[i], tf[i]);
            tests++;
            if (obs_k[0] !== tk0[i] || obs_k[1] !== 4 || obs_k[2] !== 1) begin
                failed++;
                $display("FAIL directed_latency #%0d: k=%0d/%0d/%0d required %0d/4/1",
                         i, obs_k[0], obs_k[1], obs_k[2], tk0[i]);
            end
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (obs_res[d] !== tr[i]) begin
                    failed++;
                    $display("FAIL directed_result #%0d dut%0d: {less,eq,taken,ill}=%b required %b",
                             i, d, obs_res[d], tr[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  f;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = a;
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 2) == 0) b[8*j +: 8] = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) b[31] = ~b[31];
            f = 3'($urandom_range(0, 7));
            run_req(a, b, f);
            tests++;
            if (obs_k[0] !== model_k(a, b) || obs_k[1] !== 4 || obs_k[2] !== 1) begin
                failed++;
                $display("FAIL random_latency a=%h b=%h: k=%0d/%0d/%0d required %0d/4/1",
                         a, b, obs_k[0], obs_k[1], obs_k[2], model_k(a, b));
            end
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (obs_res[d] !== model_res(a, b, f)) begin
                    failed++;
                    $display("FAIL random_result dut%0d a=%h b=%h f3=%b: %b required %b",
                             d, a, b, f, obs_res[d], model_res(a, b, f));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic [3:0]  exp;
        int          waited;
        a = $urandom;
        b = $urandom;
        exp = model_res(a, b, 3'b101);
        in_ready = 1'b0;
        @(negedge clk);
        rs1 = a; rs2 = b; f3 = 3'b101; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (vo !== 3'b111 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (vo !== 3'b111) begin
            failed++;
            $display("FAIL bp_valid_timeout: valid=%b required 111", vo);
        end
        for (int c = 0; c < 5; c++) begin
            rs1 = $urandom; rs2 = $urandom; f3 = 3'b000;
            in_valid = c[0];
            @(negedge clk);
            tests++;
            if (vo !== 3'b111 || rdy !== 3'b000) begin
                failed++;
                $display("FAIL bp_hold cycle%0d: valid=%b rdy=%b required 111/000", c, vo, rdy);
            end
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (res_o[d] !== exp) begin
                    failed++;
                    $display("FAIL bp_result cycle%0d dut%0d: %b required %b", c, d, res_o[d], exp);
                end
            end
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (vo !== 3'b000 || rdy !== 3'b111 || res_o[0] !== 4'b0000) begin
            failed++;
            $display("FAIL bp_release: valid=%b rdy=%b res=%b required 000/111/0000", vo, rdy, res_o[0]);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (vo !== 3'b000 || rdy !== 3'b111) begin
            failed++;
            $display("FAIL bp_dropped_request: valid=%b rdy=%b required 000/111", vo, rdy);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        logic [2:0]  seen_valid;
        a = $urandom;
        @(negedge clk);
        rs1 = a; rs2 = a; f3 = 3'b000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (rdy !== 3'b000) begin
            failed++;
            $display("FAIL reset_mid_ready: rdy=%b required 000", rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (vo !== 3'b000 || res_o[0] !== 4'b0000 || res_o[1] !== 4'b0000 || res_o[2] !== 4'b0000) begin
            failed++;
            $display("FAIL reset_mid_clear: valid=%b res=%b/%b/%b required all 0",
                     vo, res_o[0], res_o[1], res_o[2]);
        end
        seen_valid = '0;
        repeat (6) begin
            @(negedge clk);
            seen_valid = seen_valid | vo;
        end
        tests++;
        if (seen_valid !== 3'b000) begin
            failed++;
            $display("FAIL reset_mid_discard: valid seen=%b required 000", seen_valid);
        end
        run_req(32'h0000_0003, 32'h0000_0005, 3'b110);
        tests++;
        if (obs_k[0] !== 4 || obs_k[1] !== 4 || obs_k[2] !== 1) begin
            failed++;
            $display("FAIL reset_mid_next_latency: k=%0d/%0d/%0d required 4/4/1", obs_k[0], obs_k[1], obs_k[2]);
        end
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (obs_res[d] !== 4'b1010) begin
                failed++;
                $display("FAIL reset_mid_next_result dut%0d: %b required 1010", d, obs_res[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
